// File: rtl/retospect_cfg_loader_if.sv
// retospect_cfg_loader_if: byte stream into the scan-chain loader.
// Master supplies bytes; slave (the loader) raises byte_ready.
interface retospect_cfg_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/retospect_cfg_loader.sv
// retospect_cfg_loader: byte-wide feeder for the clockbox + 5x5 cnb scan chain.
// Define RETOSPECT_CFG_READBACK_EN to collect the old chain image off bs_return.
module retospect_cfg_loader #(
  parameter int CHAIN_LEN = 523,
  parameter int CNT_W     = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  retospect_cfg_loader_if.slave        bif,
  output logic                         config_en,
  output logic                         bs_out,
  input  logic                         bs_return,
  output logic                         nn_pulse,
  output logic                         busy,
  output logic                         done,
  output logic [7:0]                   rb_byte,
  output logic                         rb_valid
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_SHIFT  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CHAIN_LEN - 1);

  logic [1:0]       state_q, state_d;
  logic [7:0]       sreg_q, sreg_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] bit_total_q, bit_total_d;
  logic             byte_ready_q, byte_ready_d;
  logic             config_en_q, config_en_d;
  logic             bs_out_q, bs_out_d;
  logic             nn_pulse_q, nn_pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_bit;
  logic             take;

  assign last_bit = (bit_total_q == LAST);
  assign take     = bif.byte_valid & byte_ready_q;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    bit_idx_d   = bit_idx_q;
    bit_total_d = bit_total_q;
    done_d      = done_q;
    nn_pulse_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d     = S_FETCH;
          done_d      = 1'b0;
          bit_total_d = '0;
        end
      end
      S_FETCH: begin
        if (take) begin
          sreg_d    = bif.byte_in;
          bit_idx_d = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sreg_d    = {1'b0, sreg_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_total_q != TOTAL)
          bit_total_d = bit_total_q + CNT_W'(1);
        // the final byte may be partial; its leftover bits are dropped
        if (last_bit)
          state_d = S_FINISH;
        else if (bit_idx_q == 3'd7)
          state_d = S_FETCH;
      end
      S_FINISH: begin
        state_d    = S_IDLE;
        nn_pulse_d = 1'b1;
        done_d     = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d    = S_IDLE;
      nn_pulse_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  // outputs are registered copies of the next state
  always_comb begin
    byte_ready_d = (state_d == S_FETCH);
    config_en_d  = (state_d == S_SHIFT);
    bs_out_d     = (state_d == S_SHIFT) & sreg_d[0];
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sreg_q       <= '0;
      bit_idx_q    <= '0;
      bit_total_q  <= '0;
      byte_ready_q <= 1'b0;
      config_en_q  <= 1'b0;
      bs_out_q     <= 1'b0;
      nn_pulse_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      bit_idx_q    <= bit_idx_d;
      bit_total_q  <= bit_total_d;
      byte_ready_q <= byte_ready_d;
      config_en_q  <= config_en_d;
      bs_out_q     <= bs_out_d;
      nn_pulse_q   <= nn_pulse_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bif.byte_ready = byte_ready_q;
  assign config_en      = config_en_q;
  assign bs_out         = bs_out_q;
  assign nn_pulse       = nn_pulse_q;
  assign busy           = busy_q;
  assign done           = done_q;

`ifdef RETOSPECT_CFG_READBACK_EN
  logic [7:0] rb_col_q, rb_col_d;
  logic [7:0] rb_byte_q, rb_byte_d;
  logic       rb_valid_q, rb_valid_d;
  logic [7:0] rb_next;

  // bs_return is the tail bit about to leave the chain on this edge
  always_comb begin
    rb_next    = rb_col_q | (8'(bs_return) << bit_idx_q);
    rb_col_d   = rb_col_q;
    rb_byte_d  = rb_byte_q;
    rb_valid_d = 1'b0;
    if (state_q == S_SHIFT) begin
      if (bit_idx_q == 3'd7 || last_bit) begin
        rb_byte_d  = rb_next;
        rb_valid_d = 1'b1;
        rb_col_d   = '0;
      end else begin
        rb_col_d = rb_next;
      end
    end
    if (abort) begin
      rb_col_d   = '0;
      rb_byte_d  = rb_byte_q;
      rb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_col_q   <= '0;
      rb_byte_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_col_q   <= rb_col_d;
      rb_byte_q  <= rb_byte_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_byte  = rb_byte_q;
  assign rb_valid = rb_valid_q;
`else
  logic unused_bs_return;
  assign unused_bs_return = bs_return;
  assign rb_byte  = '0;
  assign rb_valid = 1'b0;
`endif

endmodule

// File: doc/retospect_cfg_loader.md
Name: retospect_cfg_loader

Overview:
- Upstream feeder for the configuration scan chain: clockbox followed by the 5x5 cnb array.
- Accepts configuration bytes over a valid/ready handshake and serialises them LSB-first onto the chain's bs_in, qualified by config_en.
- Counts exactly CHAIN_LEN bits, then issues a one-cycle reset_nn pulse to the chain and reports completion.
- Lets the top level load the array from a byte-wide port instead of bit-banging uio pins.

Parameters:
- CHAIN_LEN, 523, total scan-chain bits: clockbox 48 + 25 cnb x 19.
- CNT_W, 10, width of the bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load when idle
- abort  in  1  one-cycle pulse; cancels a load in progress
- byte_in  in  8  configuration byte; bit 0 is shifted first
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  loader accepts a byte this cycle
- config_en  out  1  drives the chain's config_en
- bs_out  out  1  drives the chain's bs_in
- bs_return  in  1  chain tail bs_out; used only with the optional feature
- nn_pulse  out  1  one-cycle pulse to the chain's reset_nn after a completed load
- busy  out  1  high in any state except IDLE
- done  out  1  sticky; set on completion, cleared by start or abort
- rb_byte  out  8  readback byte (optional feature)
- rb_valid  out  1  readback byte strobe (optional feature)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; every output 0; bit_total=0; shift register=0.
- All outputs are driven directly from flops. No combinational path runs from any input to any output.
- States: IDLE, FETCH, SHIFT, FINISH.
- IDLE: start=1 and abort=0 -> FETCH next cycle; clear done and bit_total. Start in any other state is ignored.
- FETCH: byte_ready=1.
  - On byte_valid & byte_ready: capture byte_in into sreg, clear bit_idx, go to SHIFT.
  - byte_ready drops the cycle after acceptance.
  - config_en=0 throughout FETCH.
- SHIFT: config_en=1 and bs_out=sreg[0] every cycle, so the chain samples one bit per posedge. Each cycle: sreg shifts right, bit_idx++, bit_total++.
  - bit_total reaches CHAIN_LEN -> FINISH. Remaining bits of the current byte are discarded.
  - Otherwise bit_idx reaches 8 -> FETCH.
  - config_en is high for exactly one cycle per bit shifted and never while the chain would receive a stale bit.
- FINISH: config_en=0; nn_pulse=1 for exactly one cycle; done=1; then IDLE. The chain's uT values are initialised this way.
- Abort: abort=1 in FETCH, SHIFT or FINISH -> IDLE next cycle, config_en=0, nn_pulse not issued, done=0. Abort and start in the same cycle: abort wins. Abort in IDLE clears done.
- Throughput: 1 handshake cycle + 8 shift cycles per byte. A full load is ceil(CHAIN_LEN/8)=66 bytes; the last byte contributes 3 bits.
- Backpressure: byte_valid low in FETCH holds the state indefinitely. config_en stays 0, so the chain is frozen.
- bit_total saturates at CHAIN_LEN and never wraps.
- rst_n asserted mid-load returns to IDLE immediately. The chain contents are then undefined; software must reload.

Optional Feature:
- Macro: RETOSPECT_CFG_READBACK_EN.
- Defined:
  - Each SHIFT cycle samples bs_return (the old chain contents emerging) into an 8-bit LSB-first collector.
  - Every 8th sampled bit, and on the final bit of the load, presents rb_byte with rb_valid=1 for one cycle. A partial final byte is zero-padded in its high bits.
  - No backpressure: the consumer must accept every strobe.
  - Abort discards the partial collector.
- Undefined: rb_byte=0 and rb_valid=0 constant; bs_return is unused.

Test Plan:
- Reset/idle: assert rst_n=0 mid-SHIFT -> outputs 0 immediately; after release busy=0, config_en=0, byte_ready=0.
- Full load, byte_valid held high, bytes 0x00..0x41 -> config_en high exactly 523 cycles total, 66 handshakes, one nn_pulse, done=1. A chain model's contents match the first 523 bits LSB-first.
- Backpressure: withhold byte_valid for 20 cycles after byte 3 -> config_en=0 and byte_ready=1 throughout; load then completes with an identical chain image.
- Abort during SHIFT of byte 10 -> IDLE next cycle, no nn_pulse, done=0. A subsequent start performs a clean full load.
- start while busy, and start+abort together in IDLE -> both ignored; busy unchanged.
- With RETOSPECT_CFG_READBACK_EN: preload chain image A, then load image B -> 66 rb_valid strobes reproduce A (last byte 3 bits, zero-padded).
